// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and output clamp for the KxK streaming convolution
package conv_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int COEF_W_DEF  = 8;
    localparam int SHIFT_W_DEF = 4;
    localparam int K_DEF       = 3;

    typedef logic [DATA_W_DEF-1:0]        pixel_t;
    typedef logic signed [COEF_W_DEF-1:0] coef_t;

    // Identity kernel: only the centre tap is 1, so the output is the window-centre pixel.
    localparam int KERNEL_CENTRE = 1;
    localparam coef_t KERNEL_IDENTITY [K_DEF*K_DEF] = '{
        coef_t'(0), coef_t'(0), coef_t'(0),
        coef_t'(0), coef_t'(KERNEL_CENTRE), coef_t'(0),
        coef_t'(0), coef_t'(0), coef_t'(0)
    };

    // Arithmetic right shift of the signed sum, then saturate to [0, 2**data_w-1].
    function automatic logic [31:0] clamp_pix(input logic signed [63:0] sum,
                                              input logic [7:0]         shift,
                                              input int                 data_w);
        logic signed [63:0] res;
        logic signed [63:0] max_v;
        res   = sum >>> shift;
        max_v = (64'sd1 <<< data_w) - 64'sd1;
        if (res < 64'sd0) begin
            return 32'd0;
        end else if (res > max_v) begin
            return max_v[31:0];
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - K-1 row buffers addressed by column, emitting one K-pixel column
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 540,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [K*DATA_W-1:0]   col_out
);

    // mem_q[0] holds the previous row, mem_q[b] the row b+1 above the current one.
    logic [DATA_W-1:0] mem_q [K-1][IMG_W];
    logic [DATA_W-1:0] mem_d [K-1][IMG_W];

    // Column tap: slice K-1 is the incoming pixel, lower slices are progressively older rows.
    always_comb begin
        col_out[(K-1)*DATA_W +: DATA_W] = din;
        for (int b = 0; b < K-1; b++) begin
            col_out[(K-2-b)*DATA_W +: DATA_W] = mem_q[b][addr];
        end
    end

    // On each accepted pixel every row slot at this column moves one row older.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0][addr] = din;
            for (int b = 1; b < K-1; b++) begin
                mem_d[b][addr] = mem_q[b-1][addr];
            end
        end
    end

    // Storage is deliberately left uncleared by reset; the row counter gates stale data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK convolution with handshake, programmable kernel and clamp
module conv2d_stream import conv_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COEF_W  = COEF_W_DEF,
    parameter int K       = K_DEF,
    parameter int IMG_W   = 540,
    parameter int IMG_H   = 540,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_we,
    input  logic [$clog2(K*K)-1:0]     coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last
);

    localparam int KK     = K*K;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(KK);

    logic en;
    logic accept;
    logic at_valid;
    logic at_last;
    logic [K*DATA_W-1:0] col_pix;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];
    logic signed [COEF_W-1:0] coef_q [KK];
    logic signed [COEF_W-1:0] coef_d [KK];

    logic v0_q, v0_d, last0_q, last0_d;
    logic v1_q, v1_d, last1_q, last1_d;
    logic v2_q, v2_d, last2_q, last2_d;
    logic signed [PROD_W-1:0] prod_q [KK];
    logic signed [PROD_W-1:0] prod_d [KK];
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [SUM_W-1:0]  tree_sum;
    logic m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    // A stalled output register freezes the whole pipeline, including input acceptance.
    always_comb begin
        en       = !m_valid_q || m_ready;
        accept   = s_valid && en;
        at_valid = (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
        at_last  = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
    end

    assign s_ready = en;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .K      (K),
        .IMG_W  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .en      (accept),
        .addr    (col_q),
        .din     (s_data),
        .col_out (col_pix)
    );

    // Raster position of the pixel being offered; wraps at end of row and end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left one column per accepted pixel; the new column enters at the right.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = col_pix[i*DATA_W +: DATA_W];
            end
        end
    end

    // Coefficient writes land regardless of stall; out-of-range indices are dropped.
    always_comb begin
        coef_d = coef_q;
        if (coef_we && (int'(coef_addr) < KK)) begin
            coef_d[coef_addr] = coef_wdata;
        end
    end

    // Sum of all products; widened so K*K worst-case terms cannot overflow.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < KK; k++) begin
            tree_sum = tree_sum + SUM_W'(prod_q[k]);
        end
    end

    // S0 tag, S1 multiply, S2 add, S3 shift/clamp; all advance together on en.
    always_comb begin
        v0_d      = v0_q;
        last0_d   = last0_q;
        v1_d      = v1_q;
        last1_d   = last1_q;
        prod_d    = prod_q;
        v2_d      = v2_q;
        last2_d   = last2_q;
        sum_d     = sum_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        if (en) begin
            v0_d    = accept && at_valid;
            last0_d = accept && at_last;
            v1_d    = v0_q;
            last1_d = last0_q;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    prod_d[i*K+j] = PROD_W'($signed({1'b0, win_q[i][j]})) * PROD_W'(coef_q[i*K+j]);
                end
            end
            v2_d      = v1_q;
            last2_d   = last1_q;
            sum_d     = tree_sum;
            m_valid_d = v2_q;
            m_last_d  = v2_q && last2_q;
            if (v2_q) begin
                m_data_d = DATA_W'(clamp_pix(64'(sum_q), 8'(shift), DATA_W));
            end
        end
    end

    // Control state: reset aborts any frame in flight and restores the identity kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            v0_q      <= 1'b0;
            last0_q   <= 1'b0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            v2_q      <= 1'b0;
            last2_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            for (int k = 0; k < KK; k++) begin
                coef_q[k] <= (k == KK/2) ? COEF_W'(KERNEL_CENTRE) : '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            v0_q      <= v0_d;
            last0_q   <= last0_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            v2_q      <= v2_d;
            last2_q   <= last2_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            coef_q    <= coef_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by the valid flags.
    always_ff @(posedge clk) begin
        win_q  <= win_d;
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - scoreboard bench for conv2d_stream at K=3, 5x4 frames
module tb_conv2d_stream;

    localparam int K     = 3;
    localparam int KK    = 9;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W*IMG_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_wdata = '0;
    logic [3:0] shift = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;

    conv2d_stream #(
        .DATA_W (8), .COEF_W (8), .K (K), .IMG_W (IMG_W), .IMG_H (IMG_H), .SHIFT_W (4)
    ) dut (
        .clk (clk), .rst (rst), .coef_we (coef_we), .coef_addr (coef_addr),
        .coef_wdata (coef_wdata), .shift (shift), .s_valid (s_valid), .s_ready (s_ready),
        .s_data (s_data), .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
        .m_last (m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   beats = 0;
    int   cyc = 0;
    int   kern [KK];
    int   sh = 0;
    bit   rand_ready = 1'b0;
    int   acc_cyc [NPIX];
    int   first_valid_cyc = 0;
    bit   first_seen = 1'b0;
    bit   stall_prev = 1'b0;
    int   prev_data = 0;
    int   prev_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference convolution: every valid window of the frame, raster order.
    task automatic push_frame(input int f [NPIX]);
        for (int r = K-1; r < IMG_H; r++) begin
            for (int c = K-1; c < IMG_W; c++) begin
                int   acc;
                exp_t e;
                acc = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc += kern[i*K+j] * f[(r-K+1+i)*IMG_W + (c-K+1+j)];
                acc = acc >>> sh;
                e.data = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
                e.last = (r == IMG_H-1) && (c == IMG_W-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_frame(input int f [NPIX], input bit gaps, input int n);
        for (int p = 0; p < n; p++) begin
            int t;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = f[p][7:0];
            @(negedge clk);
            t = 0;
            while (!s_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check_eq("accept_timeout", 0, 1);
            acc_cyc[p] = cyc + 1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        int v;
        v = val;
        coef_we    = 1'b1;
        coef_addr  = 4'(addr);
        coef_wdata = v[7:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (addr < KK) kern[addr] = val;
    endtask

    task automatic set_kernel(input int kv [KK]);
        for (int k = 0; k < KK; k++) write_coef(k, kv[k]);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Output monitor: pop on each handshake, and hold-check after every stalled cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", int'(m_valid), 1);
                check_eq("hold_data", int'(m_data), prev_data);
                check_eq("hold_last", int'(m_last), prev_last);
            end
            if (m_valid && !first_seen) begin
                first_seen      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("data", int'(m_data), e.data);
                    check_eq("last", int'(m_last), int'(e.last));
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = int'(m_data);
            prev_last  = int'(m_last);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp [NPIX];
        int ramp50 [NPIX];
        int c100 [NPIX];
        int c80 [NPIX];
        int c255 [NPIX];
        int imp [NPIX];
        int lap [KK];
        int box [KK];
        for (int p = 0; p < NPIX; p++) begin
            ramp[p]   = p;
            ramp50[p] = p + 50;
            c100[p]   = 100;
            c80[p]    = 80;
            c255[p]   = 255;
            imp[p]    = (p == 1*IMG_W + 1) ? 255 : 0;
        end
        lap = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        box = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < KK; k++) kern[k] = (k == KK/2) ? 1 : 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_valid", int'(m_valid), 0);
        check_eq("rst_m_last", int'(m_last), 0);
        check_eq("rst_m_data", int'(m_data), 0);
        check_eq("rst_s_ready", int'(s_ready), 1);
        rst = 1'b0;

        beats = 0;
        first_seen = 1'b0;
        push_frame(ramp);
        drive_frame(ramp, 1'b0, NPIX);
        drain("ramp");
        check_eq("ramp_beats", beats, 6);
        check_eq("latency", first_valid_cyc - acc_cyc[12], 3);

        set_kernel(lap);
        push_frame(c100);
        drive_frame(c100, 1'b0, NPIX);
        drain("lap_const");
        push_frame(imp);
        drive_frame(imp, 1'b0, NPIX);
        drain("lap_impulse");

        set_kernel(box);
        shift = 4'd3;
        sh    = 3;
        push_frame(c80);
        drive_frame(c80, 1'b0, NPIX);
        drain("box80");
        shift = 4'd0;
        sh    = 0;
        push_frame(c255);
        drive_frame(c255, 1'b0, NPIX);
        drain("box255");

        drive_frame(ramp, 1'b0, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_m_valid", int'(m_valid), 0);
        check_eq("midrst_m_last", int'(m_last), 0);
        rst = 1'b0;
        for (int k = 0; k < KK; k++) kern[k] = (k == KK/2) ? 1 : 0;
        beats = 0;
        push_frame(ramp);
        drive_frame(ramp, 1'b0, NPIX);
        drain("after_rst");
        check_eq("after_rst_beats", beats, 6);

        write_coef(9, 77);
        write_coef(15, -5);
        rand_ready = 1'b1;
        beats = 0;
        push_frame(ramp);
        drive_frame(ramp, 1'b1, NPIX);
        drain("random");
        check_eq("random_beats", beats, 6);
        rand_ready = 1'b0;
        @(posedge clk); #1;

        beats = 0;
        push_frame(ramp);
        drive_frame(ramp, 1'b0, NPIX);
        push_frame(ramp50);
        drive_frame(ramp50, 1'b0, NPIX);
        drain("b2b");
        check_eq("b2b_beats", beats, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
